// File: rtl/vme_seq_pkg.sv
// Shared types and constants for the VME command sequencer.
// Command words are 34 bits: 2-bit opcode, 16-bit instruction, 16-bit data/count.
package vme_seq_pkg;

   localparam int CMD_W = 34;

   // Direction bits OR-ed into the issued command word.
   localparam int RD_BIT = 25;
   localparam int WR_BIT = 24;

   localparam logic [31:0] DEF_CMD_MASK = 32'h00A80000;

   typedef enum logic [1:0] {
      OP_END   = 2'b00,
      OP_WRITE = 2'b01,
      OP_READ  = 2'b10,
      OP_WAIT  = 2'b11
   } opcode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_DELAY,
      ST_FINISH
   } state_t;

endpackage

// File: rtl/vme_cmd_ram.sv
// Simple dual-port command memory: one write port, one registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module vme_cmd_ram
   import vme_seq_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [CMD_W-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [CMD_W-1:0]  rd_data
);

   logic [CMD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/vme_cmd_sequencer.sv
// Executes a small program of VME commands (WRITE/READ/WAIT/END) held in an
// internal RAM, driving a strobed command interface and capturing read data.
module vme_cmd_sequencer
   import vme_seq_pkg::*;
#(
   parameter int          DEPTH    = 64,
   parameter int          ADDR_W   = $clog2(DEPTH),
   parameter logic [31:0] CMD_MASK = DEF_CMD_MASK,
   parameter int          TIMEOUT  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [CMD_W-1:0]  load_data,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              error,
   input  logic              vme_cmd_rd,
   output logic              vme_start,
   output logic [31:0]       vme_cmd_reg,
   output logic [31:0]       vme_dat_reg_in,
   input  logic              vme_dat_wr,
   input  logic [31:0]       vme_dat_reg_out,
   output logic [15:0]       rd_data,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] rd_tag
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [15:0]       cnt_reg, cnt_next;
   logic [TMR_W-1:0]  tmr_reg, tmr_next;
   logic              error_reg, error_next;
   logic              vme_start_reg, vme_start_next;
   logic [31:0]       cmd_reg, cmd_next;
   logic [31:0]       dat_reg, dat_next;
   logic              rd_valid_reg, rd_valid_next;
   logic [15:0]       rd_data_reg, rd_data_next;
   logic [ADDR_W-1:0] rd_tag_reg, rd_tag_next;

   logic [CMD_W-1:0]  ram_word;
   opcode_t           op;
   logic [15:0]       instr;
   logic [15:0]       field;
   logic [31:0]       dir_bit;
   logic              last_pc;
   state_t            adv_state;
   logic [ADDR_W-1:0] adv_pc;
   logic              unused_hi;

   vme_cmd_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (load_en && (state_reg == ST_IDLE)),
      .wr_addr (load_addr),
      .wr_data (load_data),
      .rd_en   (state_reg == ST_FETCH),
      .rd_addr (pc_reg),
      .rd_data (ram_word)
   );

   // The RAM output only updates in FETCH, so the word stays stable for the
   // whole lifetime of the command.
   assign op        = opcode_t'(ram_word[33:32]);
   assign instr     = ram_word[31:16];
   assign field     = ram_word[15:0];
   assign dir_bit   = (op == OP_READ) ? (32'd1 << RD_BIT) : (32'd1 << WR_BIT);
   assign unused_hi = ^vme_dat_reg_out[31:16];

   // The program never wraps: the last entry finishes even without END.
   assign last_pc   = (pc_reg == ADDR_W'(DEPTH - 1));
   assign adv_state = last_pc ? ST_FINISH : ST_FETCH;
   assign adv_pc    = last_pc ? pc_reg : pc_reg + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         pc_reg        <= '0;
         cnt_reg       <= '0;
         tmr_reg       <= '0;
         error_reg     <= 1'b0;
         vme_start_reg <= 1'b0;
         cmd_reg       <= CMD_MASK;
         dat_reg       <= '0;
         rd_valid_reg  <= 1'b0;
         rd_data_reg   <= '0;
         rd_tag_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         cnt_reg       <= cnt_next;
         tmr_reg       <= tmr_next;
         error_reg     <= error_next;
         vme_start_reg <= vme_start_next;
         cmd_reg       <= cmd_next;
         dat_reg       <= dat_next;
         rd_valid_reg  <= rd_valid_next;
         rd_data_reg   <= rd_data_next;
         rd_tag_reg    <= rd_tag_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      cnt_next       = cnt_reg;
      tmr_next       = tmr_reg;
      error_next     = error_reg;
      vme_start_next = 1'b0;
      cmd_next       = CMD_MASK;
      dat_next       = '0;
      rd_valid_next  = 1'b0;
      rd_data_next   = rd_data_reg;
      rd_tag_next    = rd_tag_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start && !abort) begin
               state_next = ST_FETCH;
               pc_next    = '0;
               error_next = 1'b0;
            end
         end
         ST_FETCH: state_next = ST_DECODE;
         ST_DECODE: begin
            case (op)
               OP_END: state_next = ST_FINISH;
               OP_WAIT: begin
                  if (field == 16'd0) begin
                     state_next = adv_state;
                     pc_next    = adv_pc;
                  end else begin
                     cnt_next   = field;
                     state_next = ST_DELAY;
                  end
               end
               default: begin
                  tmr_next   = '0;
                  state_next = ST_ISSUE;
               end
            endcase
         end
         ST_ISSUE: begin
            if (vme_cmd_rd) begin
               vme_start_next = 1'b1;
               cmd_next       = CMD_MASK | {16'h0, instr} | dir_bit;
               dat_next       = {16'h0, field};
               state_next     = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            // The strobe cycle itself counts toward the timeout window.
            if (vme_dat_wr) begin
               if (op == OP_READ) begin
                  rd_valid_next = 1'b1;
                  rd_data_next  = vme_dat_reg_out[15:0];
                  rd_tag_next   = pc_reg;
               end
               state_next = adv_state;
               pc_next    = adv_pc;
            end else if (tmr_reg == TMR_W'(TIMEOUT - 1)) begin
               error_next = 1'b1;
               state_next = ST_FINISH;
            end else begin
               tmr_next = tmr_reg + 1'b1;
            end
         end
         ST_DELAY: begin
            if (cnt_reg == 16'd0) begin
               state_next = adv_state;
               pc_next    = adv_pc;
            end else begin
               cnt_next = cnt_reg - 16'd1;
            end
         end
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase

      // Abort overrides everything, including a completion in the same cycle.
      if (abort && (state_reg != ST_IDLE)) begin
         state_next     = ST_IDLE;
         pc_next        = pc_reg;
         error_next     = error_reg;
         vme_start_next = 1'b0;
         cmd_next       = CMD_MASK;
         dat_next       = '0;
         rd_valid_next  = 1'b0;
         rd_data_next   = rd_data_reg;
         rd_tag_next    = rd_tag_reg;
      end
   end

   assign busy           = (state_reg != ST_IDLE);
   assign done           = (state_reg == ST_FINISH);
   assign error          = error_reg;
   assign vme_start      = vme_start_reg;
   assign vme_cmd_reg    = cmd_reg;
   assign vme_dat_reg_in = dat_reg;
   assign rd_valid       = rd_valid_reg;
   assign rd_data        = rd_data_reg;
   assign rd_tag         = rd_tag_reg;

endmodule

// File: tb/tb_vme_cmd_sequencer.sv
// Directed scoreboard bench for vme_cmd_sequencer: expected strobes and read
// results are queued as programs are loaded and popped as the DUT produces them.
module tb_vme_cmd_sequencer;
   import vme_seq_pkg::*;

   localparam int          DEPTH   = 8;
   localparam int          ADDR_W  = 3;
   localparam int          TIMEOUT = 16;
   localparam logic [31:0] MASK    = 32'h00A80000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              load_en = 1'b0;
   logic [ADDR_W-1:0] load_addr = '0;
   logic [CMD_W-1:0]  load_data = '0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              busy, done, error;
   logic              vme_cmd_rd = 1'b1;
   logic              vme_start;
   logic [31:0]       vme_cmd_reg, vme_dat_reg_in;
   logic              vme_dat_wr = 1'b0;
   logic [31:0]       vme_dat_reg_out = '0;
   logic [15:0]       rd_data;
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_tag;

   vme_cmd_sequencer #(
      .DEPTH   (DEPTH),
      .CMD_MASK(MASK),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .start          (start),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .vme_cmd_rd     (vme_cmd_rd),
      .vme_start      (vme_start),
      .vme_cmd_reg    (vme_cmd_reg),
      .vme_dat_reg_in (vme_dat_reg_in),
      .vme_dat_wr     (vme_dat_wr),
      .vme_dat_reg_out(vme_dat_reg_out),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .rd_tag         (rd_tag)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [63:0] exp_strobe_q [$];
   logic [31:0] exp_rd_q [$];

   int cyc = 0;
   int strobe_cnt = 0;
   int strobe_cyc = 0;
   int done_cnt = 0;
   int rd_cnt = 0;
   bit ack_en = 1'b0;
   int ack_delay = 0;
   int ack_cnt = 0;
   bit ack_pulse = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CMD_W-1:0] mkword(input opcode_t op, input logic [15:0] ins,
                                                input logic [15:0] dat);
      return {op, ins, dat};
   endfunction

   // Monitor and auto-responder: samples on the falling edge.
   initial begin
      logic [63:0] es;
      logic [31:0] er;
      forever begin
         @(negedge clk);
         cyc++;
         if (ack_pulse) begin
            vme_dat_wr = 1'b0;
            ack_pulse  = 1'b0;
         end
         if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
               vme_dat_wr = 1'b1;
               ack_pulse  = 1'b1;
            end
         end
         if (!rst) begin
            if (vme_start) begin
               strobe_cnt++;
               strobe_cyc = cyc;
               check("strobe_expected", 64'(exp_strobe_q.size() != 0), 64'd1);
               if (exp_strobe_q.size() != 0) begin
                  es = exp_strobe_q.pop_front();
                  check("strobe_cmd", 64'(vme_cmd_reg), 64'(es[63:32]));
                  check("strobe_dat", 64'(vme_dat_reg_in), 64'(es[31:0]));
                  $display("strobe cyc=%0d cmd=%08h dat=%08h", cyc, vme_cmd_reg, vme_dat_reg_in);
               end
               if (ack_en) begin
                  if (ack_delay == 0) begin
                     vme_dat_wr = 1'b1;
                     ack_pulse  = 1'b1;
                  end else begin
                     ack_cnt = ack_delay;
                  end
               end
            end else begin
               check("idle_cmd", 64'(vme_cmd_reg), 64'(MASK));
               check("idle_dat", 64'(vme_dat_reg_in), 64'd0);
            end
            if (rd_valid) begin
               rd_cnt++;
               check("rd_expected", 64'(exp_rd_q.size() != 0), 64'd1);
               if (exp_rd_q.size() != 0) begin
                  er = exp_rd_q.pop_front();
                  check("rd_data", 64'(rd_data), 64'(er[31:16]));
                  check("rd_tag", 64'(rd_tag), 64'(er[ADDR_W-1:0]));
                  $display("read  cyc=%0d data=%04h tag=%0d", cyc, rd_data, rd_tag);
               end
            end
            if (done) done_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic load(input int addr, input logic [CMD_W-1:0] w);
      load_en   = 1'b1;
      load_addr = ADDR_W'(addr);
      load_data = w;
      tick();
      load_en = 1'b0;
   endtask

   int t_start;
   task automatic start_run();
      start   = 1'b1;
      t_start = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check(tag, 64'(busy), 64'd0);
   endtask

   int s0, d0, r0;

   initial begin
      tick();
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_vme_start", 64'(vme_start), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      check("rst_rd_tag", 64'(rd_tag), 64'd0);
      check("rst_cmd", 64'(vme_cmd_reg), 64'(MASK));
      check("rst_dat", 64'(vme_dat_reg_in), 64'd0);
      rst = 1'b0;
      tick();

      // WRITE then END, ack three cycles after the strobe.
      load(0, mkword(OP_WRITE, 16'h4100, 16'h0003));
      load(1, mkword(OP_END, 16'h0, 16'h0));
      ack_en = 1'b1;
      ack_delay = 3;
      exp_strobe_q.push_back({32'h01A84100, 32'h00000003});
      s0 = strobe_cnt; d0 = done_cnt;
      start_run();
      wait_idle("write_end", 100);
      check("write_strobes", 64'(strobe_cnt - s0), 64'd1);
      check("write_done", 64'(done_cnt - d0), 64'd1);
      check("write_error", 64'(error), 64'd0);

      // READ then END; a second start while busy must be ignored.
      load(0, mkword(OP_READ, 16'h4200, 16'h0000));
      vme_dat_reg_out = 32'h1234BEEF;
      ack_delay = 1;
      exp_strobe_q.push_back({32'h02A84200, 32'h00000000});
      exp_rd_q.push_back({16'hBEEF, 16'd0});
      s0 = strobe_cnt; d0 = done_cnt; r0 = rd_cnt;
      start_run();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle("read_end", 100);
      check("read_strobes", 64'(strobe_cnt - s0), 64'd1);
      check("read_rd_valid", 64'(rd_cnt - r0), 64'd1);
      check("read_done", 64'(done_cnt - d0), 64'd1);

      // WAIT 5 then WRITE then END.
      load(0, mkword(OP_WAIT, 16'h0, 16'd5));
      load(1, mkword(OP_WRITE, 16'h0077, 16'h00AA));
      load(2, mkword(OP_END, 16'h0, 16'h0));
      ack_delay = 0;
      exp_strobe_q.push_back({32'h01A80077, 32'h000000AA});
      d0 = done_cnt;
      start_run();
      wait_idle("wait5_end", 100);
      check("wait5_gap_ok", 64'((strobe_cyc - (t_start + 2)) >= 5), 64'd1);
      check("wait5_done", 64'(done_cnt - d0), 64'd1);

      // WAIT 0 advances straight to the next command.
      load(0, mkword(OP_WAIT, 16'h0, 16'd0));
      exp_strobe_q.push_back({32'h01A80077, 32'h000000AA});
      s0 = strobe_cnt; d0 = done_cnt;
      start_run();
      wait_idle("wait0_end", 100);
      check("wait0_strobes", 64'(strobe_cnt - s0), 64'd1);
      check("wait0_done", 64'(done_cnt - d0), 64'd1);

      // READ with no acknowledge: timeout sets error and still pulses done.
      load(0, mkword(OP_READ, 16'h4300, 16'h0000));
      load(1, mkword(OP_END, 16'h0, 16'h0));
      ack_en = 1'b0;
      exp_strobe_q.push_back({32'h02A84300, 32'h00000000});
      d0 = done_cnt; r0 = rd_cnt;
      start_run();
      wait_idle("timeout_end", 100);
      check("timeout_error", 64'(error), 64'd1);
      check("timeout_done", 64'(done_cnt - d0), 64'd1);
      check("timeout_no_rd", 64'(rd_cnt - r0), 64'd0);
      load(0, mkword(OP_END, 16'h0, 16'h0));
      start_run();
      check("error_cleared", 64'(error), 64'd0);
      wait_idle("end_only", 20);

      // Abort in WAIT_ACK together with vme_dat_wr.
      load(0, mkword(OP_READ, 16'h4400, 16'h0000));
      exp_strobe_q.push_back({32'h02A84400, 32'h00000000});
      d0 = done_cnt; r0 = rd_cnt;
      start_run();
      for (int i = 0; i < 20 && !vme_start; i++) tick();
      check("abort_strobe_seen", 64'(vme_start), 64'd1);
      tick();
      abort = 1'b1;
      vme_dat_wr = 1'b1;
      tick();
      abort = 1'b0;
      vme_dat_wr = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      tick();
      tick();
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
      check("abort_no_rd", 64'(rd_cnt - r0), 64'd0);

      // start and abort together from IDLE: stays idle.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_idle", 64'(busy), 64'd0);

      // Memory full of WRITEs: exactly DEPTH strobes, then finish.
      ack_en = 1'b1;
      ack_delay = 0;
      for (int i = 0; i < DEPTH; i++) begin
         load(i, mkword(OP_WRITE, 16'h1000 + 16'(i), 16'(i)));
         exp_strobe_q.push_back({32'h01A81000 + 32'(i), 32'(i)});
      end
      s0 = strobe_cnt; d0 = done_cnt;
      start_run();
      wait_idle("full_end", 400);
      for (int i = 0; i < 5; i++) tick();
      check("full_strobes", 64'(strobe_cnt - s0), 64'(DEPTH));
      check("full_done", 64'(done_cnt - d0), 64'd1);
      check("full_idle", 64'(busy), 64'd0);

      check("strobe_q_empty", 64'(exp_strobe_q.size()), 64'd0);
      check("rd_q_empty", 64'(exp_rd_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
